// File: rtl/traceback_stack.sv
// LIFO reversal buffer for Viterbi traceback: bits pushed in reverse time order drain forward via valid/ready.
// Optional macro TRACEBACK_STACK_LEVEL_EN adds a registered occupancy output 'level'.
module traceback_stack #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              drain_start,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              stack_empty,
    output logic              stack_full,
    output logic              push_err,
    output logic              done
`ifdef TRACEBACK_STACK_LEVEL_EN
    ,
    output logic [ADDR_W:0]   level
`endif
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    count, count_nxt;
    logic [DATA_W-1:0]   out_data_nxt;
    logic                out_valid_nxt;
    logic                push_err_nxt;
    logic                done_nxt;
    logic                wr_en;
    logic [ADDR_W-1:0]   wr_addr;
    logic [ADDR_W-1:0]   rd_addr;
    logic [DATA_W-1:0]   mem [DEPTH];

    // The stack pointer is the low bits of count; count carries the extra bit so full never aliases empty.
    assign wr_addr     = count[ADDR_W-1:0];
    assign rd_addr     = ADDR_W'(count - CNT_W'(1));
    assign stack_full  = (count == CNT_W'(DEPTH));
    assign stack_empty = (count == '0) && !out_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        count_nxt     = count;
        out_data_nxt  = out_data;
        out_valid_nxt = out_valid;
        push_err_nxt  = push_err;
        done_nxt      = 1'b0;
        wr_en         = 1'b0;
        if (clear) begin
            state_nxt     = IDLE;
            count_nxt     = '0;
            out_data_nxt  = '0;
            out_valid_nxt = 1'b0;
            push_err_nxt  = 1'b0;
        end else begin
            case (state)
                IDLE, FILL: begin
                    if (push) begin
                        if (stack_full) begin
                            push_err_nxt = 1'b1;
                        end else begin
                            wr_en     = 1'b1;
                            count_nxt = count + CNT_W'(1);
                        end
                        state_nxt = FILL;
                    end
                    // A same-cycle push is still written before the drain begins.
                    if (drain_start) begin
                        state_nxt = DRAIN;
                    end
                end
                DRAIN: begin
                    if (push) begin
                        push_err_nxt = 1'b1;
                    end
                    if ((!out_valid || out_ready) && (count != '0)) begin
                        out_data_nxt  = mem[rd_addr];
                        out_valid_nxt = 1'b1;
                        count_nxt     = count - CNT_W'(1);
                    end else if (out_ready && (count == '0)) begin
                        out_valid_nxt = 1'b0;
                    end
                    if ((count == '0) && !out_valid) begin
                        done_nxt  = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count     <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            push_err  <= 1'b0;
            done      <= 1'b0;
        end else begin
            count     <= count_nxt;
            out_data  <= out_data_nxt;
            out_valid <= out_valid_nxt;
            push_err  <= push_err_nxt;
            done      <= done_nxt;
        end
    end

    // Storage has no reset; only entries below count are ever read.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= push_data;
        end
    end

`ifdef TRACEBACK_STACK_LEVEL_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level <= '0;
        end else begin
            level <= count_nxt;
        end
    end
`endif

endmodule
